comparador_dms_multicanal: RTL

Clocked, parametrised successor of the single ideal DMS comparator. It provides NUM_CH independent comparator channels on real-valued analog-model inputs. Each channel adds symmetric hysteresis and a consecutive-sample glitch filter, and reports its state as both a real level and a digital bit, with edge pulses and sticky event flags. It sits between the real-valued analog behavioural models and the digital control logic, and is the synchronisation point from analog-model time into the clock domain.

---
 rtl/comparador_dms_multicanal.sv | 131 +++++++++++++
 1 files changed

// File: rtl/comparador_dms_multicanal.sv
// Multi-channel clocked comparator for real-valued analog-model inputs.
// Each channel has symmetric hysteresis, a consecutive-sample filter, edge pulses and a sticky event flag.
module comparador_dms_multicanal #(
  parameter int  NUM_CH     = 4,
  parameter int  FILTER_LEN = 3,
  parameter real HYST       = 0.1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              clear_i,
  input  real               p_i [NUM_CH],
  input  real               n_i [NUM_CH],
  output real               c_o [NUM_CH],
  output logic [NUM_CH-1:0] c_bit_o,
  output logic [NUM_CH-1:0] rise_o,
  output logic [NUM_CH-1:0] fall_o,
  output logic [NUM_CH-1:0] event_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] FILT_CNT  = CW'(FILTER_LEN);
  localparam real           HALF_HYST = HYST / 2.0;

  // Bit 1 of the state is the committed level, so pending states never disturb the outputs.
  localparam logic [1:0] S_LOW       = 2'd0;
  localparam logic [1:0] S_PEND_HIGH = 2'd1;
  localparam logic [1:0] S_HIGH      = 2'd2;
  localparam logic [1:0] S_PEND_LOW  = 2'd3;

  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("comparador_dms_multicanal: NUM_CH must be >= 1");
  end
  if (FILTER_LEN < 1) begin : g_bad_filter_len
    $error("comparador_dms_multicanal: FILTER_LEN must be >= 1");
  end
  if (HYST < 0.0) begin : g_bad_hyst
    $error("comparador_dms_multicanal: HYST must be >= 0.0");
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [1:0]    state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
      logic          rise_q, rise_d;
      logic          fall_q, fall_d;
      logic          event_q, event_d;
      logic          above, below;

      assign above   = p_i[gi] > (n_i[gi] + HALF_HYST);
      assign below   = p_i[gi] < (n_i[gi] - HALF_HYST);
      assign cnt_inc = cnt_q + CW'(1);

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (!en_i) begin
          // Disabling discards partial filter progress but keeps the committed level.
          cnt_d = '0;
          if (state_q == S_PEND_HIGH) state_d = S_LOW;
          if (state_q == S_PEND_LOW)  state_d = S_HIGH;
        end else begin
          case (state_q)
            S_LOW, S_PEND_HIGH: begin
              if (above) begin
                if (cnt_inc == FILT_CNT) begin
                  state_d = S_HIGH;
                  cnt_d   = '0;
                  rise_d  = 1'b1;
                end else begin
                  state_d = S_PEND_HIGH;
                  cnt_d   = cnt_inc;
                end
              end else begin
                state_d = S_LOW;
                cnt_d   = '0;
              end
            end
            S_HIGH, S_PEND_LOW: begin
              if (below) begin
                if (cnt_inc == FILT_CNT) begin
                  state_d = S_LOW;
                  cnt_d   = '0;
                  fall_d  = 1'b1;
                end else begin
                  state_d = S_PEND_LOW;
                  cnt_d   = cnt_inc;
                end
              end else begin
                state_d = S_HIGH;
                cnt_d   = '0;
              end
            end
            default: begin
              state_d = S_LOW;
              cnt_d   = '0;
            end
          endcase
        end
        // A commit on the same edge as clear keeps the flag set.
        event_d = rise_d | fall_d | (event_q & ~clear_i);
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          state_q <= S_LOW;
          cnt_q   <= '0;
          rise_q  <= 1'b0;
          fall_q  <= 1'b0;
          event_q <= 1'b0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          rise_q  <= rise_d;
          fall_q  <= fall_d;
          event_q <= event_d;
        end
      end

      assign c_bit_o[gi] = state_q[1];
      assign c_o[gi]     = state_q[1] ? 1.0 : 0.0;
      assign rise_o[gi]  = rise_q;
      assign fall_o[gi]  = fall_q;
      assign event_o[gi] = event_q;
    end
  endgenerate

endmodule
